// File: rtl/instr_queue_2w.sv
// Dual-issue instruction queue: up to two fetched {instr, pc} pairs enter per
// cycle, and the two oldest entries are presented to decode lanes A and B.
// Circular buffer with wrapping head/tail pointers and an occupancy counter.
module instr_queue_2w #(
  parameter int               DEPTH = 8,
  parameter int               XLEN  = 32,
  parameter logic [XLEN-1:0]  NOP   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_D,
  input  logic [1:0]               ValidF,
  input  logic [XLEN-1:0]          InstrF0,
  input  logic [XLEN-1:0]          InstrF1,
  input  logic [XLEN-1:0]          PCF0,
  input  logic [XLEN-1:0]          PCF1,
  output logic                     ReadyF,
  input  logic                     TakeA_D,
  input  logic                     TakeB_D,
  output logic                     ValidA_D,
  output logic                     ValidB_D,
  output logic [XLEN-1:0]          InstrA_D,
  output logic [XLEN-1:0]          InstrB_D,
  output logic [XLEN-1:0]          PCA_D,
  output logic [XLEN-1:0]          PCB_D,
  output logic [24:0]              ImmB_D,
  output logic [$clog2(DEPTH):0]   CountQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t head, tail;
  cnt_t count;

  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];

  ptr_t head_p1;
  ptr_t wr1_addr;
  logic push_ok;
  logic take_one, take_two;
  cnt_t npush, npop;

  // Room for a full two-wide push, judged from the registered count only.
  assign ReadyF   = (count <= cnt_t'(DEPTH - 2));
  assign push_ok  = ReadyF & ~flush_D;
  assign head_p1  = head + ptr_t'(1);
  // Lane 1 lands right after lane 0 when both are valid, otherwise at tail.
  assign wr1_addr = tail + ptr_t'(ValidF[0]);

  assign ValidA_D = (count >= cnt_t'(1));
  assign ValidB_D = (count >= cnt_t'(2));

  // Pop amount: lane B only retires together with lane A.
  assign take_two = TakeA_D & TakeB_D & ValidB_D;
  assign take_one = TakeA_D & ValidA_D & ~take_two;

  // Push and pop amounts for the occupancy/pointer update.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    npush = '0;
    npop  = '0;
    if (push_ok)
      npush = cnt_t'(ValidF[0]) + cnt_t'(ValidF[1]);
    if (take_two)
      npop = cnt_t'(2);
    else if (take_one)
      npop = cnt_t'(1);
  end

  // Entry storage write; lane 0 first, in order.
  // NOTE: the storage array has no reset -- its contents are only observable
  // through count-gated slots, and resetting it would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      if (ValidF[0]) begin
        mem_instr[tail] <= InstrF0;
        mem_pc[tail]    <= PCF0;
      end
      if (ValidF[1]) begin
        mem_instr[wr1_addr] <= InstrF1;
        mem_pc[wr1_addr]    <= PCF1;
      end
    end
  end

  // Pointer and occupancy registers; flush overrides push and pop.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_D) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(npop);
      tail  <= tail + ptr_t'(npush);
      count <= count + npush - npop;
    end
  end

  // Slot read-out; invalid slots present NOP at PC 0.
  always_comb begin
    InstrA_D = NOP;
    PCA_D    = '0;
    InstrB_D = NOP;
    PCB_D    = '0;
    if (ValidA_D) begin
      InstrA_D = mem_instr[head];
      PCA_D    = mem_pc[head];
    end
    if (ValidB_D) begin
      InstrB_D = mem_instr[head_p1];
      PCB_D    = mem_pc[head_p1];
    end
  end

  assign ImmB_D = ValidB_D ? InstrB_D[31:7] : 25'd0;
  assign CountQ = count;

endmodule

// File: tb/tb_instr_queue_2w.sv
// Randomized scoreboard bench for instr_queue_2w: the driver updates a
// queue-based reference model as it issues stimulus; monitors compare DUT
// slots/occupancy each cycle and the consumed PC stream during the wrap test.
module tb_instr_queue_2w;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_D = 1'b0;
  logic [1:0]  ValidF = 2'b00;
  logic [31:0] InstrF0 = '0, InstrF1 = '0, PCF0 = '0, PCF1 = '0;
  logic        ReadyF;
  logic        TakeA_D = 1'b0, TakeB_D = 1'b0;
  logic        ValidA_D, ValidB_D;
  logic [31:0] InstrA_D, InstrB_D, PCA_D, PCB_D;
  logic [24:0] ImmB_D;
  logic [3:0]  CountQ;

  int total = 0;
  int bad = 0;

  ent_t exp_q[$];

  bit          seq_on = 1'b0;
  logic [31:0] seq_pc = '0;
  logic        sa_v, sb_v;
  logic [31:0] sa_pc, sb_pc;

  instr_queue_2w #(.DEPTH(DEPTH), .XLEN(32), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .flush_D(flush_D), .ValidF(ValidF),
    .InstrF0(InstrF0), .InstrF1(InstrF1), .PCF0(PCF0), .PCF1(PCF1),
    .ReadyF(ReadyF), .TakeA_D(TakeA_D), .TakeB_D(TakeB_D),
    .ValidA_D(ValidA_D), .ValidB_D(ValidB_D),
    .InstrA_D(InstrA_D), .InstrB_D(InstrB_D),
    .PCA_D(PCA_D), .PCB_D(PCB_D), .ImmB_D(ImmB_D), .CountQ(CountQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // Drive one cycle of stimulus and advance the reference model to match
  // the state expected after the coming rising edge.
  task automatic step(input logic [1:0] vf, input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1,
                      input logic ta, input logic tb_, input logic fl, output bit acc);
    int sz;
    bit rdy;
    @(negedge clk);
    #1;
    ValidF = vf; InstrF0 = i0; PCF0 = p0; InstrF1 = i1; PCF1 = p1;
    TakeA_D = ta; TakeB_D = tb_; flush_D = fl;
    sz  = exp_q.size();
    rdy = (DEPTH - sz) >= 2;
    acc = rdy && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (ta && sz >= 1) begin
        void'(exp_q.pop_front());
        if (tb_ && sz >= 2) void'(exp_q.pop_front());
      end
      if (rdy) begin
        if (vf[0]) exp_q.push_back('{instr: i0, pc: p0});
        if (vf[1]) exp_q.push_back('{instr: i1, pc: p1});
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic do_flush();
    bit acc;
    step(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Wait for the edge that applies the last step, then let outputs settle.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT slots and occupancy against the reference model.
  always @(negedge clk) begin
    int sz;
    logic [31:0] ia, pa, ib, pb;
    sz = exp_q.size();
    ia = (sz >= 1) ? exp_q[0].instr : NOP;
    pa = (sz >= 1) ? exp_q[0].pc : 32'h0;
    ib = (sz >= 2) ? exp_q[1].instr : NOP;
    pb = (sz >= 2) ? exp_q[1].pc : 32'h0;
    check("count",   CountQ,   sz);
    check("ready",   ReadyF,   (DEPTH - sz) >= 2);
    check("valid_a", ValidA_D, sz >= 1);
    check("valid_b", ValidB_D, sz >= 2);
    check("instr_a", InstrA_D, ia);
    check("pc_a",    PCA_D,    pa);
    check("instr_b", InstrB_D, ib);
    check("pc_b",    PCB_D,    pb);
    check("imm_b",   ImmB_D,   ib[31:7] & {25{sz >= 2}});
    sa_v = ValidA_D; sb_v = ValidB_D; sa_pc = PCA_D; sb_pc = PCB_D;
  end

  // Consumed-PC monitor: what decode takes must be a gap-free +4 stream.
  always @(posedge clk) begin
    if (seq_on && !reset && !flush_D) begin
      if (TakeA_D && sa_v) begin
        check("seq_a", sa_pc, seq_pc);
        seq_pc = seq_pc + 32'd4;
        if (TakeB_D && sb_v) begin
          check("seq_b", sb_pc, seq_pc);
          seq_pc = seq_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    bit acc;
    logic [31:0] pc;

    // Reset for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    settle();
    check("rst_valid_a", ValidA_D, 1'b0);
    check("rst_valid_b", ValidB_D, 1'b0);
    check("rst_instr_a", InstrA_D, 32'h00000013);
    check("rst_instr_b", InstrB_D, 32'h00000013);
    check("rst_imm_b",   ImmB_D,   25'h0);
    check("rst_ready",   ReadyF,   1'b1);
    check("rst_count",   CountQ,   4'd0);

    // Dual push.
    step(2'b11, 32'h00500093, 32'h0, 32'h00A00113, 32'h4, 1'b0, 1'b0, 1'b0, acc);
    settle();
    check("dual_valid_a", ValidA_D, 1'b1);
    check("dual_valid_b", ValidB_D, 1'b1);
    check("dual_pc_b",    PCB_D,    32'h4);
    check("dual_imm_b",   ImmB_D,   25'h0014002);
    check("dual_count",   CountQ,   4'd2);

    // Fill and stall.
    do_flush();
    for (int k = 0; k < 4; k++)
      step(2'b11, mk_instr(k * 8), k * 8, mk_instr(k * 8 + 4), k * 8 + 4, 1'b0, 1'b0, 1'b0, acc);
    step(2'b11, 32'hDEADBEEF, 32'h100, 32'hCAFEF00D, 32'h104, 1'b0, 1'b0, 1'b0, acc);
    settle();
    check("full_count", CountQ, 4'd8);
    check("full_ready", ReadyF, 1'b0);
    step(2'b11, 32'hDEADBEEF, 32'h100, 32'hCAFEF00D, 32'h104, 1'b1, 1'b0, 1'b0, acc);
    settle();
    check("takea_count", CountQ, 4'd7);
    check("takea_ready", ReadyF, 1'b0);
    check("takea_pc_a",  PCA_D,  32'h4);
    step(2'b00, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, acc);
    settle();
    check("take2_count", CountQ, 4'd5);
    check("take2_ready", ReadyF, 1'b1);

    // Single issue and ignored lone TakeB.
    do_flush();
    step(2'b11, mk_instr(0), 32'h0, mk_instr(4), 32'h4, 1'b0, 1'b0, 1'b0, acc);
    step(2'b00, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    settle();
    check("single_pc_a",    PCA_D,    32'h4);
    check("single_valid_b", ValidB_D, 1'b0);
    step(2'b00, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    settle();
    check("lone_b_pc_a",  PCA_D,  32'h4);
    check("lone_b_count", CountQ, 4'd1);

    // Lane-1-only push lands at tail behind the existing entry.
    step(2'b10, 32'hBAD0BAD0, 32'h900, mk_instr(8), 32'h8, 1'b0, 1'b0, 1'b0, acc);
    settle();
    check("lane1_pc_b", PCB_D, 32'h8);

    // Wrap and order: continuous dual push with random takes.
    do_flush();
    settle();
    seq_pc = 32'h0;
    seq_on = 1'b1;
    pc = 32'h0;
    for (int k = 0; k < 30; k++) begin
      step(2'b11, mk_instr(pc), pc, mk_instr(pc + 4), pc + 4,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) pc = pc + 32'd8;
    end
    for (int k = 0; k < 6; k++) step(2'b00, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, acc);
    settle();
    seq_on = 1'b0;
    check("seq_drained", seq_pc, pc);
    check("seq_empty",   CountQ, 4'd0);

    // Flush beats a same-cycle dual push and TakeA.
    step(2'b11, mk_instr(0), 32'h0, mk_instr(4), 32'h4, 1'b0, 1'b0, 1'b0, acc);
    step(2'b11, mk_instr(8), 32'h8, mk_instr(12), 32'hC, 1'b1, 1'b0, 1'b1, acc);
    settle();
    check("flush_count",   CountQ,   4'd0);
    check("flush_valid_a", ValidA_D, 1'b0);
    check("flush_instr_a", InstrA_D, 32'h00000013);
    check("flush_instr_b", InstrB_D, 32'h00000013);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 300; k++) begin
      step(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), acc);
    end

    // Asynchronous reset in the middle of the stream.
    do_flush();
    for (int k = 0; k < 3; k++)
      step(2'b11, mk_instr(k * 8), k * 8, mk_instr(k * 8 + 4), k * 8 + 4, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_count",   CountQ,   4'd0);
    check("arst_valid_a", ValidA_D, 1'b0);
    check("arst_valid_b", ValidB_D, 1'b0);
    check("arst_instr_a", InstrA_D, 32'h00000013);
    check("arst_ready",   ReadyF,   1'b1);
    exp_q.delete();
    ValidF = 2'b00; TakeA_D = 1'b0; TakeB_D = 1'b0; flush_D = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    step(2'b01, mk_instr(32'h40), 32'h40, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    settle();
    check("post_rst_pc_a", PCA_D, 32'h40);
    idle(2);

    @(negedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_queue_2w.md
Name: instr_queue_2w

Overview:
- Dual-issue instruction queue between fetch (F) and the two decode lanes (A, B) of the superscalar core.
- Accepts up to two fetched instructions with PCs per cycle and presents the two oldest entries to decode lanes A and B.
- Lane B's immediate field, ImmB_D = InstrB_D[31:7], feeds the lane-B immediate extender directly.
- Absorbs fetch/decode rate mismatch, single-issue cycles and branch flushes.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- XLEN, 32, instruction and PC width.
- NOP, 32'h00000013, instruction value driven on an invalid decode slot.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_D  in  1  synchronous queue clear (branch redirect).
- ValidF  in  2  bit0 = lane-0 fetch valid; bit1 = lane-1 fetch valid.
- InstrF0, InstrF1  in  XLEN  fetched instructions; lane 0 is older.
- PCF0, PCF1  in  XLEN  PCs of InstrF0 and InstrF1.
- ReadyF  out  1  queue can accept a two-instruction push this cycle.
- TakeA_D, TakeB_D  in  1  decode consumes slot A / slot B this cycle.
- ValidA_D, ValidB_D  out  1  slot A / slot B holds a valid entry.
- InstrA_D, InstrB_D  out  XLEN  oldest / second-oldest instruction.
- PCA_D, PCB_D  out  XLEN  PCs of slot A / slot B.
- ImmB_D  out  25  InstrB_D[31:7], to the lane-B immediate extender.
- CountQ  out  log2(DEPTH)+1  current occupancy (debug/perf).

Behaviour:
- Storage is a circular buffer of {instr, pc}.
  - head and tail are log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Reset, asynchronous: head=tail=count=0.
  - ValidA_D=ValidB_D=0, InstrA_D=InstrB_D=NOP, PCA_D=PCB_D=0, ImmB_D=0, ReadyF=1, CountQ=0.
  - Storage array is not reset.
- ReadyF = (DEPTH - count >= 2), computed from registered count only. Same-cycle pops do not raise it.
- Push: occurs only when ReadyF=1; ValidF is ignored when ReadyF=0, and fetch must hold its data.
  - Valid lanes are written in order, lane 0 first, at tail and tail+1.
  - ValidF=2'b10: only lane 1 is written, at tail.
  - Push amount np = popcount(ValidF).
- Slot outputs are read combinationally from storage at head and head+1 (mod DEPTH).
  - ValidA_D = (count>=1); ValidB_D = (count>=2).
  - An invalid slot drives instr=NOP, pc=0.
  - Write-to-visible latency is 1 cycle; there is no bypass from ValidF to the slots.
- Pop amount:
  - npop = 1 if TakeA_D & ValidA_D & !(TakeB_D & ValidB_D).
  - npop = 2 if TakeA_D & TakeB_D & ValidB_D.
  - npop = 0 otherwise. TakeB_D without TakeA_D is ignored; takes on invalid slots are ignored.
- Update: head += npop, tail += np, count += np - npop. Simultaneous push and pop in one cycle is legal.
- Flush has priority over push and pop in the same cycle: next state is head=tail=count=0, and that cycle's fetch data is discarded.
- Reset asserted mid-operation aborts everything immediately (asynchronous); the queue is empty after release.
- Order is strictly FIFO across wrap-around; no entry is duplicated or lost.

Test Plan:
- Reset: assert reset for 3 cycles, release -> ValidA_D=ValidB_D=0, InstrA_D=InstrB_D=32'h00000013, ImmB_D=0, ReadyF=1, CountQ=0.
- Dual push: ValidF=2'b11, InstrF0=32'h00500093 @PC 0x0, InstrF1=32'h00A00113 @PC 0x4 -> next cycle ValidA_D=ValidB_D=1, PCB_D=0x4, ImmB_D=25'h0014002, CountQ=2.
- Fill and stall: 4 dual pushes with no takes -> CountQ=8, ReadyF=0; pushing again leaves the queue unchanged. TakeA_D only -> CountQ=7, ReadyF still 0. Then both takes -> CountQ=5, ReadyF=1.
- Single issue: queue holds PCs 0x0/0x4; TakeA_D=1, TakeB_D=0 -> next cycle PCA_D=0x4, ValidB_D=0. TakeB_D=1 alone -> no change.
- Wrap and order: 30 cycles of continuous dual push with random takes on PCs 0x0, 0x4, 0x8... -> the PC sequence consumed by decode is strictly +4 with no gaps across pointer wrap; CountQ matches the reference model every cycle.
- Flush and mid-op reset: flush_D in the same cycle as a dual push and TakeA_D -> next cycle CountQ=0, both slots invalid/NOP. Async reset mid-stream -> outputs go to reset values before the next clock edge.
